// File: rtl/dna_syn_pkg.sv
// Shared types and constants for the weighted-syndrome digit link.
package dna_syn_pkg;

  typedef logic [1:0] digit_t;

  localparam int SUM_W      = 14;
  localparam int CHK_DIGITS = 7;
  // Wide enough for data index 0..11 and check index 0..6.
  localparam int IDX_W      = 4;

  typedef enum logic [1:0] {IDLE, DATA, CHECK, PARITY} tx_state_t;

  // A zero digit weighs 4 so that an all-zero word still has a non-zero syndrome.
  function automatic logic [2:0] digit_weight(input digit_t d);
    return (d == 2'b00) ? 3'd4 : {1'b0, d};
  endfunction

endpackage

// File: rtl/dna_syn_tx_if.sv
// Handshake bundle for dna_syn_tx: parallel word input and serial digit output.
// The slave modport is the transmitter; the master modport is its environment.
interface dna_syn_tx_if #(parameter int N = 6);
  import dna_syn_pkg::*;

  logic [2*N-1:0] word_in;
  logic           word_valid;
  logic           word_ready;
  digit_t         dig_out;
  logic           dig_valid;
  logic           dig_ready;
  logic           dig_last;
  logic           dig_is_chk;

  modport master (
    output word_in, word_valid, dig_ready,
    input  word_ready, dig_out, dig_valid, dig_last, dig_is_chk
  );

  modport slave (
    input  word_in, word_valid, dig_ready,
    output word_ready, dig_out, dig_valid, dig_last, dig_is_chk
  );

endinterface

// File: rtl/dna_syn_acc.sv
// Syndrome accumulator: sum += digit_weight(d) * pos when en, cleared by clr.
module dna_syn_acc
  import dna_syn_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  digit_t           d,
  input  logic [IDX_W-1:0] pos,
  output logic [SUM_W-1:0] sum
);

  logic [SUM_W-1:0] prod;

  // Both operands widened first so the product cannot truncate.
  assign prod = {{(SUM_W-3){1'b0}}, digit_weight(d)} * {{(SUM_W-IDX_W){1'b0}}, pos};

  // Accumulate one weighted digit per accepted data transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + prod;
    end
  end

endmodule

// File: rtl/dna_syn_tx.sv
// Weighted-syndrome digit transmitter: serialises an N-digit word (digit 0 first),
// then appends the 14-bit syndrome as 7 check digits, MSB pair first.
// Optional: define DNA_SYN_TX_PARITY_EN to append one XOR parity digit after the checks.
module dna_syn_tx
  import dna_syn_pkg::*;
#(
  parameter int N = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  dna_syn_tx_if.slave      bus,
  output logic [SUM_W-1:0] syn_out,
  output logic             frame_done
);

  tx_state_t        state, state_next;
  logic [2*N-1:0]   word_sh;
  logic [IDX_W-1:0] idx;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] chk_shift;
  logic             ready;
  logic             accept, xfer;
  logic             data_end, chk_end, frame_end;
  digit_t           dig_out;
  logic             dig_valid, dig_last, dig_is_chk;
`ifdef DNA_SYN_TX_PARITY_EN
  digit_t           par;
`endif

  assign accept    = bus.word_valid && ready && (state == IDLE);
  assign xfer      = dig_valid && bus.dig_ready;
  assign data_end  = (state == DATA)  && (idx == IDX_W'(N - 1));
  assign chk_end   = (state == CHECK) && (idx == IDX_W'(CHK_DIGITS - 1));
  // Bring the check digit for index idx to the top two bits.
  assign chk_shift = sum << {idx, 1'b0};

`ifdef DNA_SYN_TX_PARITY_EN
  assign frame_end = (state == PARITY) && xfer;
`else
  assign frame_end = chk_end && xfer;
`endif

  assign bus.word_ready = ready;
  assign bus.dig_out    = dig_out;
  assign bus.dig_valid  = dig_valid;
  assign bus.dig_last   = dig_last;
  assign bus.dig_is_chk = dig_is_chk;

  dna_syn_acc u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (xfer && (state == DATA)),
    .d     (word_sh[1:0]),
    .pos   (idx + 1'b1),
    .sum   (sum)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and digit-side outputs; outputs depend only on state so they hold during stalls.
  always_comb begin
    state_next = state;
    dig_out    = 2'b00;
    dig_valid  = 1'b0;
    dig_last   = 1'b0;
    dig_is_chk = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = DATA;
      end
      DATA: begin
        dig_valid = 1'b1;
        dig_out   = word_sh[1:0];
        if (xfer && data_end) state_next = CHECK;
      end
      CHECK: begin
        dig_valid  = 1'b1;
        dig_is_chk = 1'b1;
        dig_out    = chk_shift[SUM_W-1 -: 2];
`ifdef DNA_SYN_TX_PARITY_EN
        if (xfer && chk_end) state_next = PARITY;
`else
        dig_last = chk_end;
        if (xfer && chk_end) state_next = IDLE;
`endif
      end
      PARITY: begin
`ifdef DNA_SYN_TX_PARITY_EN
        dig_valid  = 1'b1;
        dig_is_chk = 1'b1;
        dig_last   = 1'b1;
        dig_out    = par;
        if (xfer) state_next = IDLE;
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Word shifter, digit index, ready flag and end-of-frame reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_sh    <= '0;
      idx        <= '0;
      ready      <= 1'b0;
      syn_out    <= '0;
      frame_done <= 1'b0;
    end else begin
      ready      <= (state_next == IDLE);
      frame_done <= frame_end;
      if (frame_end) syn_out <= sum;
      if (accept) begin
        word_sh <= bus.word_in;
        idx     <= '0;
      end else if (xfer && (state == DATA)) begin
        word_sh <= word_sh >> 2;
        idx     <= data_end ? '0 : idx + 1'b1;
      end else if (xfer && (state == CHECK)) begin
        idx     <= chk_end ? '0 : idx + 1'b1;
      end
    end
  end

`ifdef DNA_SYN_TX_PARITY_EN
  // Running XOR of every raw digit sent so far in the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      par <= 2'b00;
    else if (accept) par <= 2'b00;
    else if (xfer)   par <= par ^ dig_out;
  end
`endif

endmodule

// File: tb/tb_dna_syn_tx.sv
// Directed self-checking bench for dna_syn_tx (N=6). Honours DNA_SYN_TX_PARITY_EN.
module tb_dna_syn_tx;
  import dna_syn_pkg::*;

  localparam int N = 6;
`ifdef DNA_SYN_TX_PARITY_EN
  localparam int FLEN = N + CHK_DIGITS + 1;
`else
  localparam int FLEN = N + CHK_DIGITS;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [SUM_W-1:0] syn_out;
  logic             frame_done;

  dna_syn_tx_if #(.N(N)) bus ();

  dna_syn_tx #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .syn_out    (syn_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Capture of the most recent frame.
  logic [1:0]       cap_dig [16];
  logic             cap_last[16];
  logic             cap_chk [16];
  int               cap_n;
  int               cap_stall_err;
  int               cap_stalls;
  bit               cap_timeout;
  logic [SUM_W-1:0] cap_syn;
  logic             cap_done;
  logic             cap_done_after;

  // Present one word at a negedge once the block is idle; returns at the first digit cycle.
  task automatic start_word(input logic [11:0] w);
    int n = 0;
    while (bus.word_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.word_in    = w;
    bus.word_valid = 1'b1;
    @(negedge clk);
    bus.word_valid = 1'b0;
  endtask

  // Drain one frame; bp=1 drives dig_ready 1,0,0,1,0,0,...
  task automatic collect(input int bp);
    logic       prev_stall, prev_last, prev_chk;
    logic [1:0] prev_dig;
    bit         done;
    prev_stall = 1'b0; prev_last = 1'b0; prev_chk = 1'b0; prev_dig = 2'b00; done = 1'b0;
    cap_n = 0; cap_stall_err = 0; cap_stalls = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      bus.dig_ready = (bp == 0) ? 1'b1 : ((k % 3) == 0);
      if (prev_stall && (bus.dig_out !== prev_dig || bus.dig_last !== prev_last ||
                         bus.dig_is_chk !== prev_chk))
        cap_stall_err++;
      if (bus.dig_valid !== 1'b1) cap_stall_err++;
      if (bus.dig_valid === 1'b1 && bus.dig_ready === 1'b1) begin
        if (cap_n < 16) begin
          cap_dig[cap_n]  = bus.dig_out;
          cap_last[cap_n] = bus.dig_last;
          cap_chk[cap_n]  = bus.dig_is_chk;
        end
        cap_n++;
        if (bus.dig_last === 1'b1) done = 1'b1;
      end
      prev_stall = (bus.dig_valid === 1'b1) && (bus.dig_ready === 1'b0);
      if (prev_stall) cap_stalls++;
      prev_dig  = bus.dig_out;
      prev_last = bus.dig_last;
      prev_chk  = bus.dig_is_chk;
      @(negedge clk);
    end
    cap_timeout    = !done;
    cap_done       = frame_done;
    cap_syn        = syn_out;
    bus.dig_ready  = 1'b1;
    @(negedge clk);
    cap_done_after = frame_done;
    $display("frame: digits=%0d syn_out=%0d stalls=%0d", cap_n, cap_syn, cap_stalls);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.word_ready !== 1'b0 || bus.dig_valid !== 1'b0 || bus.dig_out !== 2'b00 ||
        bus.dig_last !== 1'b0 || bus.dig_is_chk !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b valid=%b dig=%b last=%b chk=%b, expected all 0",
               bus.word_ready, bus.dig_valid, bus.dig_out, bus.dig_last, bus.dig_is_chk);
    end
    checks++;
    if (syn_out !== 14'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_syn: got syn_out=%0d frame_done=%b, expected 0 0", syn_out, frame_done);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.word_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready: got %b, expected 0 before first edge", bus.word_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.word_ready !== 1'b1 || bus.dig_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got ready=%b valid=%b, expected 1 0", bus.word_ready, bus.dig_valid);
    end
    $display("reset: word_ready=%b", bus.word_ready);
  endtask

  task automatic test_zero_word();
    logic [1:0] exp[14] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                            2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1};
    start_word(12'h000);
    collect(0);
    checks++;
    if (cap_timeout || cap_n != FLEN) begin
      errors++;
      $display("FAIL zero_len: got %0d digits timeout=%0d, expected %0d", cap_n, cap_timeout, FLEN);
    end
    for (int i = 0; i < FLEN; i++) begin
      checks++;
      if (cap_dig[i] !== exp[i] || cap_chk[i] !== (i >= N) || cap_last[i] !== (i == FLEN - 1)) begin
        errors++;
        $display("FAIL zero_digit[%0d]: got dig=%b chk=%b last=%b, expected dig=%b chk=%b last=%b",
                 i, cap_dig[i], cap_chk[i], cap_last[i], exp[i], i >= N, i == FLEN - 1);
      end
    end
    checks++;
    if (cap_syn !== 14'd84) begin
      errors++;
      $display("FAIL zero_syn: got %0d, expected 84", cap_syn);
    end
    checks++;
    if (cap_done !== 1'b1 || cap_done_after !== 1'b0) begin
      errors++;
      $display("FAIL zero_done_pulse: got %b then %b, expected 1 then 0", cap_done, cap_done_after);
    end
  endtask

  task automatic test_mixed_word();
    logic [1:0] exp[14] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
                            2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd0, 2'd3};
    start_word(12'b11_10_01_00_11_10);
    collect(0);
    checks++;
    if (cap_timeout || cap_n != FLEN) begin
      errors++;
      $display("FAIL mixed_len: got %0d digits timeout=%0d, expected %0d", cap_n, cap_timeout, FLEN);
    end
    for (int i = 0; i < FLEN; i++) begin
      checks++;
      if (cap_dig[i] !== exp[i] || cap_chk[i] !== (i >= N)) begin
        errors++;
        $display("FAIL mixed_digit[%0d]: got dig=%b chk=%b, expected dig=%b chk=%b",
                 i, cap_dig[i], cap_chk[i], exp[i], i >= N);
      end
    end
    checks++;
    if (cap_syn !== 14'd52 || cap_done !== 1'b1) begin
      errors++;
      $display("FAIL mixed_syn: got syn=%0d done=%b, expected 52 1", cap_syn, cap_done);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] exp[14] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
                            2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd0, 2'd3};
    start_word(12'b11_10_01_00_11_10);
    collect(1);
    checks++;
    if (cap_timeout || cap_n != FLEN) begin
      errors++;
      $display("FAIL bp_len: got %0d digits timeout=%0d, expected %0d", cap_n, cap_timeout, FLEN);
    end
    for (int i = 0; i < FLEN; i++) begin
      checks++;
      if (cap_dig[i] !== exp[i] || cap_last[i] !== (i == FLEN - 1)) begin
        errors++;
        $display("FAIL bp_digit[%0d]: got dig=%b last=%b, expected dig=%b last=%b",
                 i, cap_dig[i], cap_last[i], exp[i], i == FLEN - 1);
      end
    end
    checks++;
    if (cap_stall_err != 0 || cap_stalls == 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d unstable/invalid cycles over %0d stalls, expected 0 over >0",
               cap_stall_err, cap_stalls);
    end
    checks++;
    if (cap_syn !== 14'd52 || cap_done !== 1'b1 || cap_done_after !== 1'b0) begin
      errors++;
      $display("FAIL bp_syn: got syn=%0d done=%b/%b, expected 52 1/0", cap_syn, cap_done, cap_done_after);
    end
  endtask

  task automatic test_mid_reset();
    logic [1:0] exp[14] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
                            2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
    int bad_done = 0;
    bus.dig_ready = 1'b1;
    start_word(12'b11_10_01_00_11_10);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.dig_valid !== 1'b0 || bus.word_ready !== 1'b0 || bus.dig_out !== 2'b00 ||
        bus.dig_is_chk !== 1'b0 || bus.dig_last !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got valid=%b ready=%b dig=%b chk=%b last=%b, expected all 0",
               bus.dig_valid, bus.word_ready, bus.dig_out, bus.dig_is_chk, bus.dig_last);
    end
    checks++;
    if (syn_out !== 14'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_syn: got syn_out=%0d frame_done=%b, expected 0 0", syn_out, frame_done);
    end
    repeat (2) begin
      @(negedge clk);
      if (frame_done !== 1'b0) bad_done++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (frame_done !== 1'b0) bad_done++;
    checks++;
    if (bus.word_ready !== 1'b1 || bad_done != 0) begin
      errors++;
      $display("FAIL midrst_recover: got ready=%b spurious_done=%0d, expected 1 0", bus.word_ready, bad_done);
    end
    start_word(12'h555);
    collect(0);
    checks++;
    if (cap_timeout || cap_n != FLEN) begin
      errors++;
      $display("FAIL midrst_len: got %0d digits timeout=%0d, expected %0d", cap_n, cap_timeout, FLEN);
    end
    for (int i = 0; i < FLEN; i++) begin
      checks++;
      if (cap_dig[i] !== exp[i]) begin
        errors++;
        $display("FAIL midrst_digit[%0d]: got %b, expected %b", i, cap_dig[i], exp[i]);
      end
    end
    checks++;
    if (cap_syn !== 14'd21) begin
      errors++;
      $display("FAIL midrst_syn_after: got %0d, expected 21", cap_syn);
    end
  endtask

  task automatic test_back_to_back();
    int acc_k[$];
    int busy_err = 0;
    int n = 0;
    bus.dig_ready  = 1'b1;
    bus.word_in    = 12'h555;
    bus.word_valid = 1'b1;
    for (int k = 0; k < 4 * (FLEN + 1) + 4; k++) begin
      if (bus.word_ready === 1'b1) acc_k.push_back(k);
      if (bus.dig_valid === 1'b1 && bus.word_ready !== 1'b0) busy_err++;
      @(negedge clk);
    end
    bus.word_valid = 1'b0;
    checks++;
    if (acc_k.size() < 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d accepts, expected at least 4", acc_k.size());
    end
    for (int i = 1; i < acc_k.size(); i++) begin
      checks++;
      if (acc_k[i] - acc_k[i-1] != FLEN + 1) begin
        errors++;
        $display("FAIL b2b_gap[%0d]: got %0d cycles, expected %0d", i, acc_k[i] - acc_k[i-1], FLEN + 1);
      end
      $display("accept: cycle=%0d", acc_k[i]);
    end
    checks++;
    if (busy_err != 0) begin
      errors++;
      $display("FAIL b2b_busy_ready: got %0d cycles with word_ready during frame, expected 0", busy_err);
    end
    while (bus.word_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.word_ready !== 1'b1 || syn_out !== 14'd21) begin
      errors++;
      $display("FAIL b2b_drain: got ready=%b syn_out=%0d, expected 1 21", bus.word_ready, syn_out);
    end
  endtask

  task automatic test_last_flag();
    start_word(12'h555);
    collect(0);
    checks++;
    if (cap_n != FLEN || cap_timeout) begin
      errors++;
      $display("FAIL last_len: got %0d digits, expected %0d", cap_n, FLEN);
    end
    checks++;
    if (cap_last[FLEN-1] !== 1'b1 || cap_last[FLEN-2] !== 1'b0) begin
      errors++;
      $display("FAIL last_position: got last[%0d]=%b last[%0d]=%b, expected 1 0",
               FLEN - 1, cap_last[FLEN-1], FLEN - 2, cap_last[FLEN-2]);
    end
    checks++;
    if (cap_dig[FLEN-1] !== 2'b01 || cap_chk[FLEN-1] !== 1'b1) begin
      errors++;
      $display("FAIL last_digit: got dig=%b chk=%b, expected 01 1", cap_dig[FLEN-1], cap_chk[FLEN-1]);
    end
  endtask

  initial begin
    bus.word_in    = '0;
    bus.word_valid = 1'b0;
    bus.dig_ready  = 1'b1;
    test_reset();
    test_zero_word();
    test_mixed_word();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    test_last_flag();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
